// File: rtl/pulse_train_generator_if.sv
// Handshake bundle for pulse_train_generator: train request inputs and pulse/status outputs.
// The master side drives requests; the slave side is the generator itself.
interface pulse_train_generator_if #(
   parameter int COUNTER_WIDTH = 16,
   parameter int PULSE_WIDTH   = 8
);
   logic                     i_start;
   logic                     i_abort;
   logic [COUNTER_WIDTH-1:0] i_high_cycles;
   logic [COUNTER_WIDTH-1:0] i_low_cycles;
   logic [PULSE_WIDTH-1:0]   i_num_pulses;
   logic                     o_ready;
   logic                     o_out;
   logic                     o_rising;
   logic                     o_falling;
   logic                     o_done;

   modport master (
      output i_start, i_abort, i_high_cycles, i_low_cycles, i_num_pulses,
      input  o_ready, o_out, o_rising, o_falling, o_done
   );

   modport slave (
      input  i_start, i_abort, i_high_cycles, i_low_cycles, i_num_pulses,
      output o_ready, o_out, o_rising, o_falling, o_done
   );
endinterface

// File: rtl/pulse_train_generator.sv
// Programmable pulse train: N pulses of H high cycles separated by L low cycles.
// Moore FSM; every output is a flop or a decode of the state register.
module pulse_train_generator #(
   parameter int COUNTER_WIDTH = 16,
   parameter int PULSE_WIDTH   = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   pulse_train_generator_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_HIGH,
      S_LOW,
      S_DONE
   } state_t;

   localparam logic [COUNTER_WIDTH-1:0] CNT_ONE   = COUNTER_WIDTH'(1);
   localparam logic [PULSE_WIDTH-1:0]   PULSE_ONE = PULSE_WIDTH'(1);

   state_t                   r_state;
   logic [COUNTER_WIDTH-1:0] r_cnt;
   logic [COUNTER_WIDTH-1:0] r_high_m1;
   logic [COUNTER_WIDTH-1:0] r_low_m1;
   logic [PULSE_WIDTH-1:0]   r_pulses_left;
   logic                     r_out;
   logic                     r_rising;
   logic                     r_falling;
   logic                     r_done;

   // Phase length minus one, with a zero length treated as a single cycle.
   function automatic logic [COUNTER_WIDTH-1:0] len_m1(input logic [COUNTER_WIDTH-1:0] len);
      return (len == '0) ? '0 : len - CNT_ONE;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         r_high_m1     <= '0;
         r_low_m1      <= '0;
         r_pulses_left <= '0;
         r_out         <= 1'b0;
         r_rising      <= 1'b0;
         r_falling     <= 1'b0;
         r_done        <= 1'b0;
      end else begin
         r_rising  <= 1'b0;
         r_falling <= 1'b0;
         r_done    <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.i_start) begin
                  r_high_m1     <= len_m1(bus.i_high_cycles);
                  r_low_m1      <= len_m1(bus.i_low_cycles);
                  r_pulses_left <= bus.i_num_pulses;
                  if (bus.i_num_pulses == '0) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state  <= S_HIGH;
                     r_out    <= 1'b1;
                     r_rising <= 1'b1;
                     r_cnt    <= len_m1(bus.i_high_cycles);
                  end
               end
            end
            S_HIGH: begin
               if (bus.i_abort) begin
                  r_state   <= S_DONE;
                  r_out     <= 1'b0;
                  r_falling <= 1'b1;
                  r_done    <= 1'b1;
               end else if (r_cnt == '0) begin
                  r_out     <= 1'b0;
                  r_falling <= 1'b1;
                  // The last pulse goes straight to DONE without a trailing LOW phase.
                  if (r_pulses_left == PULSE_ONE) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state       <= S_LOW;
                     r_cnt         <= r_low_m1;
                     r_pulses_left <= r_pulses_left - PULSE_ONE;
                  end
               end else begin
                  r_cnt <= r_cnt - CNT_ONE;
               end
            end
            S_LOW: begin
               if (bus.i_abort) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end else if (r_cnt == '0) begin
                  r_state  <= S_HIGH;
                  r_out    <= 1'b1;
                  r_rising <= 1'b1;
                  r_cnt    <= r_high_m1;
               end else begin
                  r_cnt <= r_cnt - CNT_ONE;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
               r_out   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.o_ready   = (r_state == S_IDLE);
   assign bus.o_out     = r_out;
   assign bus.o_rising  = r_rising;
   assign bus.o_falling = r_falling;
   assign bus.o_done    = r_done;

endmodule

// File: tb/tb_pulse_train_generator.sv
// Bench for pulse_train_generator: waveform-queue model checked every cycle,
// plus directed trains with hand-computed expectations.
module tb_pulse_train_generator;
   localparam int CW = 16;
   localparam int PW = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pulse_train_generator_if #(.COUNTER_WIDTH(CW), .PULSE_WIDTH(PW)) bus ();

   pulse_train_generator #(.COUNTER_WIDTH(CW), .PULSE_WIDTH(PW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   bit cmp_en = 1'b0;

   // Model: on accept, expand the whole train into a queue of out values.
   bit m_out = 1'b0, m_rise = 1'b0, m_fall = 1'b0, m_done = 1'b0, m_ready = 1'b1, m_busy = 1'b0;
   bit m_prev;
   bit m_q[$];
   int m_h, m_l, m_n;

   always @(posedge clk) begin
      cyc = cyc + 1;
      m_prev = m_out;
      if (rst) begin
         m_q.delete();
         m_busy = 0; m_out = 0; m_rise = 0; m_fall = 0; m_done = 0; m_ready = 1;
      end else begin
         if (m_done) begin
            m_done  = 0;
            m_ready = 1;
         end else if (m_ready) begin
            if (bus.i_start) begin
               m_h = (bus.i_high_cycles == 0) ? 1 : int'(bus.i_high_cycles);
               m_l = (bus.i_low_cycles == 0) ? 1 : int'(bus.i_low_cycles);
               m_n = int'(bus.i_num_pulses);
               m_q.delete();
               for (int p = 0; p < m_n; p++) begin
                  for (int k = 0; k < m_h; k++) m_q.push_back(1'b1);
                  if (p < m_n - 1)
                     for (int k = 0; k < m_l; k++) m_q.push_back(1'b0);
               end
               m_busy  = 1;
               m_ready = 0;
            end
         end else if (bus.i_abort) begin
            m_q.delete();
         end
         if (m_busy) begin
            if (m_q.size() > 0) begin
               m_out = m_q.pop_front();
            end else begin
               m_out  = 0;
               m_done = 1;
               m_busy = 0;
            end
         end
         m_rise = !m_prev && m_out;
         m_fall = m_prev && !m_out;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      if (cmp_en) begin
         check($sformatf("out@%0d", cyc),     32'(bus.o_out),     32'(m_out));
         check($sformatf("rising@%0d", cyc),  32'(bus.o_rising),  32'(m_rise));
         check($sformatf("falling@%0d", cyc), 32'(bus.o_falling), 32'(m_fall));
         check($sformatf("done@%0d", cyc),    32'(bus.o_done),    32'(m_done));
         check($sformatf("ready@%0d", cyc),   32'(bus.o_ready),   32'(m_ready));
      end
   endtask

   logic [32:1] c_out, c_rise, c_fall, c_done, c_ready;
   int n_rise, n_done, done_at;

   // Issue start in "cycle 0"; returns at the sample point of cycle 1.
   task automatic start_train(input int h, input int l, input int n);
      bus.i_high_cycles = CW'(h);
      bus.i_low_cycles  = CW'(l);
      bus.i_num_pulses  = PW'(n);
      bus.i_start       = 1'b1;
      tick();
      bus.i_start = 1'b0;
   endtask

   // Record cycles 1..ncyc; abort/start/rst are driven during the given cycles.
   task automatic run(input int ncyc, input int abort_at, input int s1, input int s2, input int rst_at);
      c_out = '0; c_rise = '0; c_fall = '0; c_done = '0; c_ready = '0;
      n_rise = 0; n_done = 0; done_at = 0;
      for (int i = 1; i <= ncyc; i++) begin
         if (i <= 32) begin
            c_out[i]   = bus.o_out;
            c_rise[i]  = bus.o_rising;
            c_fall[i]  = bus.o_falling;
            c_done[i]  = bus.o_done;
            c_ready[i] = bus.o_ready;
         end
         if (bus.o_rising) n_rise++;
         if (bus.o_done) begin
            n_done++;
            if (done_at == 0) done_at = i;
         end
         bus.i_abort = (i == abort_at);
         bus.i_start = (i == s1) || (i == s2);
         rst         = (i == rst_at);
         tick();
      end
      bus.i_abort = 1'b0;
      bus.i_start = 1'b0;
      rst         = 1'b0;
   endtask

   int rh, rl, rn, rlen;

   initial begin
      bus.i_start = 1'b0;
      bus.i_abort = 1'b0;
      bus.i_high_cycles = '0;
      bus.i_low_cycles  = '0;
      bus.i_num_pulses  = '0;

      // Reset held for two cycles
      tick();
      cmp_en = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      check("rst_out",     32'(bus.o_out),     32'd0);
      check("rst_rising",  32'(bus.o_rising),  32'd0);
      check("rst_falling", 32'(bus.o_falling), 32'd0);
      check("rst_done",    32'(bus.o_done),    32'd0);
      check("rst_ready",   32'(bus.o_ready),   32'd1);

      // H=3 L=2 N=2
      start_train(3, 2, 2);
      run(10, 0, 0, 0, 0);
      check("t2_out",     32'(c_out[10:1]),   32'b0011100111);
      check("t2_rising",  32'(c_rise[10:1]),  32'b0000100001);
      check("t2_falling", 32'(c_fall[10:1]),  32'b0100001000);
      check("t2_done",    32'(c_done[10:1]),  32'b0100000000);
      check("t2_ready",   32'(c_ready[10:1]), 32'b1000000000);

      // N=0: done only
      start_train(5, 5, 0);
      run(3, 0, 0, 0, 0);
      check("t3a_done",  32'(c_done[3:1]),  32'b001);
      check("t3a_out",   32'(c_out[3:1]),   32'b000);
      check("t3a_ready", 32'(c_ready[3:1]), 32'b110);
      check("t3a_rise",  32'(n_rise),       32'd0);

      // H=0 L=0 N=3 behaves as H=1 L=1
      start_train(0, 0, 3);
      run(7, 0, 0, 0, 0);
      check("t3b_out",     32'(c_out[6:1]),  32'b010101);
      check("t3b_rising",  32'(c_rise[6:1]), 32'b010101);
      check("t3b_falling", 32'(c_fall[6:1]), 32'b101010);
      check("t3b_done",    32'(c_done[6:1]), 32'b100000);
      check("t3b_ready7",  32'(c_ready[7]),  32'd1);

      // H=4 L=1 N=3 with starts while busy and changed inputs
      start_train(4, 1, 3);
      bus.i_high_cycles = CW'(1);
      bus.i_low_cycles  = CW'(7);
      bus.i_num_pulses  = PW'(9);
      run(20, 0, 2, 5, 0);
      check("t4_nrise",  32'(n_rise),  32'd3);
      check("t4_ndone",  32'(n_done),  32'd1);
      check("t4_doneat", 32'(done_at), 32'd15);

      // Abort in HIGH
      start_train(5, 5, 4);
      run(6, 3, 0, 0, 0);
      check("t5a_out",     32'(c_out[4:1]),   32'b0111);
      check("t5a_falling", 32'(c_fall[4]),    32'd1);
      check("t5a_done",    32'(c_done[4:1]),  32'b1000);
      check("t5a_ready",   32'(c_ready[5:4]), 32'b10);

      // Abort in LOW
      start_train(5, 5, 4);
      run(10, 7, 0, 0, 0);
      check("t5b_out",     32'(c_out[8:6]),   32'b000);
      check("t5b_done",    32'(c_done[8]),    32'd1);
      check("t5b_falling", 32'(c_fall[8]),    32'd0);
      check("t5b_ready",   32'(c_ready[9:8]), 32'b10);
      check("t5b_ndone",   32'(n_done),       32'd1);

      // Reset mid-HIGH, then a full train
      start_train(5, 2, 2);
      run(6, 0, 0, 0, 2);
      check("t6_out",     32'(c_out[3:2]),  32'b01);
      check("t6_ready",   32'(c_ready[3]),  32'd1);
      check("t6_done",    32'(n_done),      32'd0);
      check("t6_falling", 32'(c_fall[3]),   32'd0);
      start_train(2, 3, 3);
      run(16, 0, 0, 0, 0);
      check("t6_nrise",  32'(n_rise),  32'd3);
      check("t6_doneat", 32'(done_at), 32'd13);

      // Maximum pulse count
      start_train(1, 1, 255);
      run(512, 0, 0, 0, 0);
      check("max_nrise",  32'(n_rise),  32'd255);
      check("max_doneat", 32'(done_at), 32'd510);

      // Random trains in 1..20
      for (int t = 0; t < 3; t++) begin
         rh = int'($urandom_range(1, 20));
         rl = int'($urandom_range(1, 20));
         rn = int'($urandom_range(1, 20));
         rlen = rn * rh + (rn - 1) * rl;
         start_train(rh, rl, rn);
         run(rlen + 3, 0, 0, 0, 0);
         check($sformatf("rnd%0d_nrise", t),  32'(n_rise),  32'(rn));
         check($sformatf("rnd%0d_doneat", t), 32'(done_at), 32'(rlen + 1));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
